uart_frame_tx: RTL
==================

Name: uart_frame_tx

Overview:
- Parametrised UART frame transmitter. Accepts a whole multi-byte command frame, for example the 40-bit 0x0D-header commands, in one valid/ready handshake.
- Serialises the frame as back-to-back 8N1-style characters on a single tx line.
- Generates its own bit timing from the system clock, so no separate baud-rate generator or per-byte load/start sequencing is needed.
- Sits between host/BLE command logic and the UART pins.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division, must be >= 2.
- FRAME_BYTES, 5, bytes per frame; must be >= 1.
- STOP_BITS, 1, number of stop bits per character; 1 or 2.
- MSB_BYTE_FIRST, 0:
  - 0 sends frame_data[7:0] first.
  - 1 sends frame_data[8*FRAME_BYTES-1 -: 8] first.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_data  in  8*FRAME_BYTES  frame payload; sampled on accept.
- frame_valid  in  1  frame_data is valid.
- frame_ready  out  1  block can accept a frame (high only in IDLE).
- tx  out  1  serial output; idles high.
- busy  out  1  high from the accept cycle until the cycle after the last stop bit ends.
- byte_done  out  1  one-cycle pulse at the end of each character's final stop bit.
- frame_done  out  1  one-cycle pulse at the end of the frame; coincides with the last byte_done.

Behaviour:
- Clock and reset: single clock clk. Synchronous active-high reset applied on the clk edge.
- Reset values:
  - tx=1, frame_ready=1, busy=0, byte_done=0, frame_done=0.
  - State IDLE; bit counter, byte counter and baud counter all 0.
- Accept: frame_valid && frame_ready at a rising edge latches frame_data into the shift register.
  - frame_ready drops and busy rises in the next cycle.
  - tx goes low (start bit) in that same next cycle.
- State machine: IDLE -> START -> DATA -> STOP -> (START for the next byte | IDLE).
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and restarts on each state entry.
  - START drives tx=0.
  - DATA drives 8 bits LSB-first.
  - STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Byte order: bytes are consumed in the order set by MSB_BYTE_FIRST. There is no inter-character gap: the next start bit directly follows the stop bit(s).
- Frame duration: FRAME_BYTES*(9+STOP_BITS)*CLKS_PER_BIT cycles from the first tx=0 to the frame_done pulse, inclusive of the final stop time.
- End of frame: frame_done pulses in the cycle the state returns to IDLE.
  - frame_ready is high from the following cycle.
  - A new frame therefore needs at least one idle cycle; tx stays high throughout.
- Busy handling:
  - frame_valid while busy is ignored. No queueing, no error flag.
  - frame_data changes after accept have no effect.
- Reset mid-frame: the state machine aborts at the next edge.
  - tx=1, all counters are cleared.
  - No byte_done or frame_done pulse is generated.
- Width rule: the byte counter is $clog2(FRAME_BYTES+1) bits wide and wraps only by returning to IDLE.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- When defined:
  - An extra character is sent after the last payload byte.
  - The character is the XOR of all FRAME_BYTES payload bytes, computed at accept time.
  - byte_done pulses for the checksum character too.
  - frame_done pulses only after the checksum's stop bit(s).
  - Frame duration becomes (FRAME_BYTES+1)*(9+STOP_BITS)*CLKS_PER_BIT.
- When undefined: exactly FRAME_BYTES characters are sent and no checksum logic exists.

Test Plan:
1. CLOCK_FREQ=1000000, BAUD_RATE=100000 (10 clk/bit), FRAME_BYTES=5, MSB_BYTE_FIRST=0. Send frame_data=40'h0D00000003.
   - Decoded bytes: 03,00,00,00,0D.
   - frame_done 500 cycles after the first start-bit edge.
   - 5 byte_done pulses.
2. Same frame, MSB_BYTE_FIRST=1 -> decoded order 0D,00,00,00,03; each bit held exactly 10 cycles.
3. STOP_BITS=2, FRAME_BYTES=1, data 8'hA5.
   - tx pattern: 0,1,0,1,0,0,1,0,1,1,1, each held 10 cycles.
   - frame_done at cycle 110.
4. Assert frame_valid with 40'h0D00000001 mid-frame.
   - Ignored; only the first frame is transmitted.
   - Second frame accepted only after frame_ready returns; it starts at least 1 cycle after frame_done.
5. Assert reset during byte 2's DATA state -> tx=1 next cycle, frame_ready=1, busy=0, no frame_done pulse; a subsequent frame transmits correctly.
6. With UART_FRAME_CHECKSUM_EN, send 40'h0D00000003 -> 6 characters, the last being 0E; frame_done after 600 cycles.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises a whole FRAME_BYTES-wide frame as back-to-back 8N1-style characters.
// Optional macro UART_FRAME_CHECKSUM_EN appends an XOR-of-payload checksum character.
`default_nettype none

module uart_frame_tx #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int FRAME_BYTES    = 5,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     byte_done,
  output logic                     frame_done
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int FW           = 8 * FRAME_BYTES;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NUM_CHARS    = FRAME_BYTES + 1;
`else
  localparam int NUM_CHARS    = FRAME_BYTES;
`endif
  localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW           = $clog2(FRAME_BYTES + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NUM_CHARS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state, state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] char_cnt;
  logic [FW-1:0] shreg;
  logic [7:0]    payload_byte;
  logic [7:0]    cur_byte;
  logic          accept;
  logic          baud_last;
  logic          char_end;
  logic          last_char;

  assign accept    = frame_valid && frame_ready;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign char_end  = (state == S_STOP) && baud_last && (bit_cnt == STOP_LAST);
  assign last_char = (char_cnt == CHAR_LAST);

  generate
    if (MSB_BYTE_FIRST != 0) begin : g_msb_first
      assign payload_byte = shreg[FW-1 -: 8];
    end else begin : g_lsb_first
      assign payload_byte = shreg[7:0];
    end
  endgenerate

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum, csum_next;

  always_comb begin
    csum_next = '0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      csum_next = csum_next ^ frame_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum_next;
    end
  end

  // The checksum character follows the last payload byte.
  assign cur_byte = (char_cnt == CW'(FRAME_BYTES)) ? csum : payload_byte;
`else
  assign cur_byte = payload_byte;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_START;
      S_START: if (baud_last) state_next = S_DATA;
      S_DATA:  if (baud_last && bit_cnt == 3'd7) state_next = S_STOP;
      S_STOP:  if (char_end) state_next = last_char ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx          = 1'b1;
    busy        = (state != S_IDLE) || frame_done;
    frame_ready = !busy;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_byte[bit_cnt];
      default: tx = 1'b1;
    endcase
  end

  // Counters restart on every state entry; bit_cnt doubles as the stop-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      char_cnt   <= '0;
      shreg      <= '0;
      byte_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      byte_done  <= char_end;
      frame_done <= char_end && last_char;

      if (state == S_IDLE || baud_last) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end

      if (state == S_IDLE) begin
        bit_cnt <= '0;
      end else if (baud_last) begin
        bit_cnt <= (state_next != state) ? 3'd0 : bit_cnt + 3'd1;
      end

      if (char_end) begin
        char_cnt <= last_char ? '0 : char_cnt + CW'(1);
      end

      if (accept) begin
        shreg <= frame_data;
      end else if (char_end) begin
        if (MSB_BYTE_FIRST != 0) begin
          shreg <= shreg << 8;
        end else begin
          shreg <= shreg >> 8;
        end
      end
    end
  end

endmodule

`default_nettype wire
